keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives the 3x4 matrix keypad, debounces presses and emits one clean key code per press.
//  Sits directly upstream of the game-state stage, which consumes key_data and key_valid to mark board cells.
//  Only codes 1..9 are board moves; '*', '0' and '#' get distinct codes so the consumer can ignore them.
// PARAMETERS
//  SCAN_DIV      25000  clk cycles per scan tick (column dwell time)
//  DEBOUNCE_CNT  20     consecutive stable scan ticks required for press and for release
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  en         in   1  1 = accept keys; 0 = FSM forced to IDLE, no key_valid
//  key_row    in   4  keypad rows, active-high (1 = key in driven column closed)
//  key_col    out  3  one-hot column drive
//  key_data   out  4  code of held key: 1..9 digits, 10='*', 11='0', 12='#'; 0 = no key
//  key_valid  out  1  one-clk pulse when a debounced press is accepted
//  key_held   out  1  high while the accepted key is still down
// BEHAVIOUR
//  Reset values: key_col=3'b001, key_data=0, key_valid=0, key_held=0; state IDLE; all counters 0.
//  Tick: prescaler counts 0..SCAN_DIV-1; tick is a 1-clk strobe when it wraps. Free-running, even with en=0.
//  Rows are sampled only on tick, i.e. after a full dwell in the current column.
//  In IDLE, key_col rotates 001->010->100->001 on each tick, after the sample. In all other states it is frozen.
//  Code map for row r (0..3) and column c (0..2): r<3 -> 3r+c+1; r=3 -> 10+c.
//  Valid sample: exactly one row bit set. Zero bits, or two or more bits, count as "no key".
//  FSM, with transitions evaluated on tick:
//   IDLE: valid sample -> store code, cnt=1, go to DEBOUNCE.
//   DEBOUNCE: same code -> cnt+1. Different code or no key -> IDLE, cnt=0.
//     When cnt reaches DEBOUNCE_CNT -> PRESSED.
//     On the same clk: key_data=code, key_valid=1 for exactly one clk, key_held=1.
//   PRESSED: no-key sample -> rcnt+1. Any key sample -> rcnt=0. A second key does not change key_data.
//     When rcnt reaches DEBOUNCE_CNT -> IDLE; on the same clk key_data=0 and key_held=0.
//  Press latency: DEBOUNCE_CNT ticks after the first valid sample. Auto-repeat: none; one key_valid per press.
//  en=0 at any time: next clk state=IDLE, key_data=0, key_held=0, key_valid=0.
//    Column rotation resumes from its current value; a press in progress is discarded.
//  rst mid-press: all outputs return to reset values on the next clk.
//    The still-held key must pass a full DEBOUNCE again before it can issue a new key_valid.
//  key_valid and a release never coincide. tick and rst together: rst wins.
//  Counter widths: prescaler $clog2(SCAN_DIV); cnt and rcnt $clog2(DEBOUNCE_CNT+1); no wrap past terminal value.
// TESTING  (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3)
//  1. rst, no keys -> key_col 001,010,100,001 changing every 4 clk; key_data=0; key_valid never 1.
//  2. Hold row1 high while col=010 (key 5) -> after 3 ticks one key_valid pulse, key_data=5, key_held=1.
//     Release -> key_data=0 three ticks later.
//  3. Row0/col0 bounce pattern 1,0,1,1,1 across ticks -> exactly one key_valid with key_data=1, after the final 3 stable ticks.
//  4. Rows 0 and 2 high together in col 100 -> treated as no key: column keeps rotating, no key_valid.
//  5. Key 9 accepted, then key 3 also pressed, then 9 released -> key_data stays 9 until 3 stable no-key ticks.
//     No second key_valid while 3 is held.
//  6. en=0 during DEBOUNCE of '#' (code 12), and separately rst while PRESSED -> outputs 0 next clk.
//     Re-pressing requires a full 3-tick debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// Scans a 3x4 matrix keypad one column at a time, debounces presses and releases
// over whole scan ticks, and reports one key code per accepted press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 25000,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StPressed
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [2:0]    col_q, col_d;
    logic [3:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [3:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic          tick;
    logic [3:0]    col_off;
    logic [3:0]    sample_code;
    logic [2:0]    col_rot;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] rcnt_inc;

    assign tick     = (presc_q == PRESC_MAX);
    assign col_rot  = {col_q[1:0], col_q[2]};
    assign cnt_inc  = cnt_q + 1'b1;
    assign rcnt_inc = rcnt_q + 1'b1;

    // Free-running prescaler; keeps counting while en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Row sample decode: exactly one row bit gives a code, anything else reads as no key
    always_comb begin
        case (col_q)
            3'b010:  col_off = 4'd1;
            3'b100:  col_off = 4'd2;
            default: col_off = 4'd0;
        endcase
        case (key_row)
            4'b0001: sample_code = 4'd1 + col_off;
            4'b0010: sample_code = 4'd4 + col_off;
            4'b0100: sample_code = 4'd7 + col_off;
            4'b1000: sample_code = 4'd10 + col_off;
            default: sample_code = 4'd0;
        endcase
    end

    // Next-state and output logic; the scan only advances on tick
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        held_d  = held_q;

        if (!en) begin
            state_d = StIdle;
            code_d  = '0;
            cnt_d   = '0;
            rcnt_d  = '0;
            data_d  = '0;
            held_d  = 1'b0;
            if (tick && (state_q == StIdle)) begin
                col_d = col_rot;
            end
        end else if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (sample_code != 4'd0) begin
                        // Column stays put so the same key is sampled while debouncing
                        code_d = sample_code;
                        cnt_d  = CW'(1);
                        if (CNT_MAX == CW'(1)) begin
                            state_d = StPressed;
                            data_d  = sample_code;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end else begin
                            state_d = StDebounce;
                        end
                    end else begin
                        col_d = col_rot;
                    end
                end
                StDebounce: begin
                    if (sample_code == code_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d = StPressed;
                            data_d  = code_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    if (sample_code == 4'd0) begin
                        rcnt_d = rcnt_inc;
                        if (rcnt_inc == CNT_MAX) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                            rcnt_d  = '0;
                            data_d  = '0;
                            held_d  = 1'b0;
                        end
                    end else begin
                        rcnt_d = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= 3'b001;
            code_q  <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign key_col   = col_q;
    assign key_data  = data_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model feeds the rows, and a tick-level
// reference model predicts column drive, key code, valid pulse and held flag.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 3;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [3:0]  key_data;
    logic        key_valid;
    logic        key_held;

    // Physical switches: index r*3+c is closed when the bit is set
    logic [11:0] pressed;

    int n_checks;
    int n_fail;

    keypad_scanner #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a row reads high if any closed switch sits in a driven column
    assign key_row = {|(pressed[11:9] & key_col), |(pressed[8:6] & key_col),
                      |(pressed[5:3] & key_col),  |(pressed[2:0] & key_col)};

    // Reference model, kept as counts and codes rather than a state machine
    int   m_presc;
    int   m_col;        // column index 0..2
    int   m_pend;       // code being debounced, 0 = none
    int   m_stab;       // consecutive matching samples of m_pend
    int   m_held_code;  // accepted key, 0 = none
    int   m_rel;        // consecutive no-key samples while a key is accepted
    logic m_valid;

    always @(posedge clk) begin : model
        int   code;
        int   nrow;
        int   hit_row;
        logic tk;
        if (rst) begin
            m_presc = 0; m_col = 0; m_pend = 0; m_stab = 0;
            m_held_code = 0; m_rel = 0; m_valid = 1'b0;
        end else begin
            tk      = (m_presc == SD - 1);
            m_presc = tk ? 0 : m_presc + 1;
            m_valid = 1'b0;
            nrow    = 0;
            hit_row = 0;
            for (int r = 0; r < 4; r++) begin
                if (pressed[r*3 + m_col]) begin
                    nrow++;
                    hit_row = r;
                end
            end
            code = (nrow != 1) ? 0 : ((hit_row < 3) ? 3*hit_row + m_col + 1 : 10 + m_col);
            if (!en) begin
                if (tk && m_pend == 0 && m_held_code == 0) m_col = (m_col + 1) % 3;
                m_pend = 0; m_stab = 0; m_held_code = 0; m_rel = 0;
            end else if (tk) begin
                if (m_held_code != 0) begin
                    if (code == 0) begin
                        m_rel++;
                        if (m_rel == DC) begin
                            m_held_code = 0;
                            m_rel = 0;
                        end
                    end else begin
                        m_rel = 0;
                    end
                end else if (m_pend != 0) begin
                    if (code == m_pend) begin
                        m_stab++;
                        if (m_stab == DC) begin
                            m_held_code = m_pend;
                            m_valid = 1'b1;
                            m_pend = 0;
                            m_stab = 0;
                        end
                    end else begin
                        m_pend = 0;
                        m_stab = 0;
                    end
                end else if (code != 0) begin
                    m_pend = code;
                    m_stab = 1;
                end else begin
                    m_col = (m_col + 1) % 3;
                end
            end
        end
    end

    logic [8:0] act_vec;
    logic [8:0] exp_vec;
    assign act_vec = {key_col, key_data, key_valid, key_held};
    assign exp_vec = {3'(3'b001 << m_col), 4'(m_held_code), m_valid, (m_held_code != 0)};

    localparam logic [8:0] RESET_VEC = {3'b001, 4'd0, 1'b0, 1'b0};

    task automatic test_reset();
        logic [2:0] exp_col;
        rst = 1'b1; en = 1'b1; pressed = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (act_vec !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_state: got %b required %b", act_vec, RESET_VEC);
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_col = 3'(3'b001 << (((i + 1) / SD) % 3));
            n_checks++;
            if (key_col !== exp_col || key_data !== 4'd0 || key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_rotate cyc %0d: got col=%b data=%0d valid=%b required col=%b data=0 valid=0",
                         i, key_col, key_data, key_valid, exp_col);
            end
        end
    endtask

    task automatic test_key5();
        int nvalid = 0;
        int vdata = 0;
        pressed = '0;
        pressed[4] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL key5_press cyc %0d: got %b required %b", i, act_vec, exp_vec);
            end
            if (key_valid) begin
                nvalid++;
                vdata = int'(key_data);
            end
        end
        n_checks++;
        if (nvalid != 1 || vdata != 5 || key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL key5_pulse: got %0d pulses data=%0d held=%b required 1 pulse data=5 held=1",
                     nvalid, vdata, key_held);
        end
        pressed = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL key5_release cyc %0d: got %b required %b", i, act_vec, exp_vec);
            end
        end
        n_checks++;
        if (key_data !== 4'd0 || key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL key5_cleared: got data=%0d held=%b required data=0 held=0", key_data, key_held);
        end
    endtask

    task automatic test_bounce();
        int pattern[5] = '{1, 0, 1, 1, 1};
        int nvalid = 0;
        int vwin = -1;
        int vdata = 0;
        bit aligned = 0;
        pressed = '0;
        for (int i = 0; i < 40 && !aligned; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL bounce_align cyc %0d: got %b required %b", i, act_vec, exp_vec);
            end
            aligned = (m_presc == 0 && key_col === 3'b001);
        end
        n_checks++;
        if (!aligned) begin
            n_fail++;
            $display("FAIL bounce_align_timeout: got col=%b required col=001 just after a tick", key_col);
        end
        for (int k = 0; k < 5; k++) begin
            pressed[0] = (pattern[k] != 0);
            for (int i = 0; i < SD; i++) begin
                @(negedge clk);
                n_checks++;
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL bounce_step %0d cyc %0d: got %b required %b", k, i, act_vec, exp_vec);
                end
                if (key_valid) begin
                    nvalid++;
                    vwin = k;
                    vdata = int'(key_data);
                end
            end
        end
        n_checks++;
        if (nvalid != 1 || vwin != 4 || vdata != 1) begin
            n_fail++;
            $display("FAIL bounce_pulse: got %0d pulses in window %0d data=%0d required 1 pulse in window 4 data=1",
                     nvalid, vwin, vdata);
        end
        pressed = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_double_row();
        int nvalid = 0;
        int nchg = 0;
        logic [2:0] prev;
        pressed = '0;
        pressed[2] = 1'b1;
        pressed[8] = 1'b1;
        prev = key_col;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL double_row cyc %0d: got %b required %b", i, act_vec, exp_vec);
            end
            if (key_valid) nvalid++;
            if (key_col !== prev) nchg++;
            prev = key_col;
        end
        n_checks++;
        if (nvalid != 0 || nchg != 12) begin
            n_fail++;
            $display("FAIL double_row_scan: got %0d pulses %0d col changes required 0 pulses 12 col changes",
                     nvalid, nchg);
        end
        pressed = '0;
    endtask

    task automatic test_rollover();
        bit seen = 0;
        int nvalid = 0;
        pressed = '0;
        pressed[8] = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rollover_press cyc %0d: got %b required %b", i, act_vec, exp_vec);
            end
            seen = (key_valid === 1'b1);
        end
        n_checks++;
        if (!seen || key_data !== 4'd9) begin
            n_fail++;
            $display("FAIL rollover_accept: got seen=%0d data=%0d required seen=1 data=9", seen, key_data);
        end
        pressed[2] = 1'b1;
        repeat (SD) @(negedge clk);
        pressed[8] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec || key_data !== 4'd9) begin
                n_fail++;
                $display("FAIL rollover_hold cyc %0d: got %b required %b (data 9)", i, act_vec, exp_vec);
            end
            if (key_valid) nvalid++;
        end
        n_checks++;
        if (nvalid != 0) begin
            n_fail++;
            $display("FAIL rollover_no_repeat: got %0d pulses required 0", nvalid);
        end
        pressed = '0;
        repeat (16) @(negedge clk);
        n_checks++;
        if (key_data !== 4'd0 || key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL rollover_release: got data=%0d held=%b required data=0 held=0", key_data, key_held);
        end
    endtask

    task automatic test_en_rst();
        bit started = 0;
        int vcyc = -1;
        int nvalid = 0;
        pressed = '0;
        pressed[11] = 1'b1;
        for (int i = 0; i < 40 && !started; i++) begin
            @(negedge clk);
            started = (m_pend != 0);
        end
        n_checks++;
        if (!started) begin
            n_fail++;
            $display("FAIL en_debounce_start: got no debounce start required one within 40 clk");
        end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (key_data !== 4'd0 || key_held !== 1'b0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL en_off: got data=%0d held=%b valid=%b required 0 0 0", key_data, key_held, key_valid);
        end
        repeat (7) @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL en_redebounce cyc %0d: got %b required %b", i, act_vec, exp_vec);
            end
            if (key_valid) begin
                nvalid++;
                if (vcyc < 0) vcyc = i;
            end
        end
        n_checks++;
        if (nvalid != 1 || vcyc < 2*SD || key_data !== 4'd12) begin
            n_fail++;
            $display("FAIL en_repress: got %0d pulses at cyc %0d data=%0d required 1 pulse at cyc>=%0d data=12",
                     nvalid, vcyc, key_data, 2*SD);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (act_vec !== RESET_VEC) begin
            n_fail++;
            $display("FAIL rst_pressed: got %b required %b", act_vec, RESET_VEC);
        end
        nvalid = 0;
        vcyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rst_redebounce cyc %0d: got %b required %b", i, act_vec, exp_vec);
            end
            if (key_valid) begin
                nvalid++;
                if (vcyc < 0) vcyc = i;
            end
        end
        n_checks++;
        if (nvalid != 1 || vcyc < 2*SD) begin
            n_fail++;
            $display("FAIL rst_repress: got %0d pulses at cyc %0d required 1 pulse at cyc>=%0d",
                     nvalid, vcyc, 2*SD);
        end
        pressed = '0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        int dur;
        int mode;
        for (int s = 0; s < 60; s++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) pressed = '0;
            else if (mode == 1) pressed = 12'(1 << $urandom_range(0, 11));
            else if (mode == 2) pressed = 12'((1 << $urandom_range(0, 11)) | (1 << $urandom_range(0, 11)));
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 31) == 0);
            dur = int'($urandom_range(1, 48));
            for (int i = 0; i < dur; i++) begin
                @(negedge clk);
                rst = 1'b0;
                n_checks++;
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL random seg %0d cyc %0d: got %b required %b", s, i, act_vec, exp_vec);
                end
            end
        end
        rst = 1'b0;
        en = 1'b1;
        pressed = '0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        en       = 1'b1;
        pressed  = '0;
        test_reset();
        test_key5();
        test_bounce();
        test_double_row();
        test_rollover();
        test_en_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
